// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder that resolves one digit per clock, LSD first.
// Optional macro BCD_SUB_EN adds a 'sub' input (nine's complement of b for a - b).
module bcd_serial_adder #(
    parameter int NDIGITS = 4,
    parameter int IDXW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4*NDIGITS-1:0] a,
    input  logic [4*NDIGITS-1:0] b,
    input  logic                 Cin,
`ifdef BCD_SUB_EN
    input  logic                 sub,
`endif
    output logic [4*NDIGITS-1:0] s,
    output logic                 Cout,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int W = 4 * NDIGITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    // Operand conditioning at the start edge: validity flags and effective b.
    logic [NDIGITS-1:0] a_bad;
    logic [NDIGITS-1:0] b_bad;
    logic [W-1:0]       b_eff;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_operand
            assign a_bad[gi] = (a[4*gi +: 4] > 4'd9);
            assign b_bad[gi] = (b[4*gi +: 4] > 4'd9);
`ifdef BCD_SUB_EN
            assign b_eff[4*gi +: 4] = sub ? (4'd9 - b[4*gi +: 4]) : b[4*gi +: 4];
`else
            assign b_eff[4*gi +: 4] = b[4*gi +: 4];
`endif
        end
    endgenerate

    // Select the digit pair addressed by idx.
    logic [3:0] cur_a;
    logic [3:0] cur_b;

    always_comb begin
        cur_a = 4'd0;
        cur_b = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_a = a_q[4*i +: 4];
                cur_b = b_q[4*i +: 4];
            end
        end
    end

    // One digit of decimal addition; the +6 correction is applied even to non-BCD input.
    logic [4:0] dig_sum;
    logic [4:0] dig_adj;
    logic [3:0] dig_out;
    logic       dig_carry;

    always_comb begin
        dig_sum = {1'b0, cur_a} + {1'b0, cur_b} + {4'd0, carry_q};
        dig_adj = dig_sum + 5'd6;
        if (dig_sum > 5'd9) begin
            dig_out   = dig_adj[3:0];
            dig_carry = 1'b1;
        end else begin
            dig_out   = dig_sum[3:0];
            dig_carry = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = Cin;
                    s_d     = '0;
                    idx_d   = '0;
                    err_d   = |{a_bad, b_bad};
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int i = 0; i < NDIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[4*i +: 4] = dig_out;
                    end
                end
                carry_d = dig_carry;
                // Top digit finishes the operation; idx parks at 0 rather than wrapping.
                if (idx_q == LAST_IDX) begin
                    cout_d  = dig_carry;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign s    = s_q;
    assign Cout = cout_q;
    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (NDIGITS=4); sub cases run when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        Cin;
    logic [15:0] s;
    logic        Cout;
    logic        busy;
    logic        done;
    logic        err;
`ifdef BCD_SUB_EN
    logic        sub;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(
        .NDIGITS(4),
        .IDXW   (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .a    (a),
        .b    (b),
        .Cin  (Cin),
`ifdef BCD_SUB_EN
        .sub  (sub),
`endif
        .s    (s),
        .Cout (Cout),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; returns 1 time unit after that edge.
    task automatic go(input logic [15:0] av, input logic [15:0] bv, input logic c);
        a     = av;
        b     = bv;
        Cin   = c;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        Cin   = 1'b0;
`ifdef BCD_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        check("rst_s", 32'(s), 32'h0);
        check("rst_cout", 32'(Cout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b0;

        // 1234 + 5678
        go(16'h1234, 16'h5678, 1'b0);
        check("t1_busy_e0", 32'(busy), 32'h1);
        check("t1_s_clear", 32'(s), 32'h0);
        check("t1_err", 32'(err), 32'h0);
        step(3);
        check("t1_busy_e3", 32'(busy), 32'h1);
        check("t1_done_e3", 32'(done), 32'h0);
        step(1);
        check("t1_done_e4", 32'(done), 32'h1);
        check("t1_busy_e4", 32'(busy), 32'h0);
        check("t1_s", 32'(s), 32'h6912);
        check("t1_cout", 32'(Cout), 32'h0);
        step(1);
        check("t1_done_drop", 32'(done), 32'h0);
        check("t1_s_hold", 32'(s), 32'h6912);

        // 9999 + 0001 and 0000 + 0000 + Cin
        go(16'h9999, 16'h0001, 1'b0);
        step(4);
        check("t2_done", 32'(done), 32'h1);
        check("t2_s", 32'(s), 32'h0000);
        check("t2_cout", 32'(Cout), 32'h1);
        step(1);
        go(16'h0000, 16'h0000, 1'b1);
        step(4);
        check("t2b_s", 32'(s), 32'h0001);
        check("t2b_cout", 32'(Cout), 32'h0);

        // Non-BCD digit flags err but the operation still completes
        step(1);
        go(16'h12A4, 16'h0001, 1'b0);
        check("t3_err", 32'(err), 32'h1);
        step(4);
        check("t3_done", 32'(done), 32'h1);
        check("t3_s", 32'(s), 32'h1305);
        check("t3_err_hold", 32'(err), 32'h1);
        step(1);
        go(16'h0001, 16'h0001, 1'b0);
        check("t3b_err", 32'(err), 32'h0);
        step(4);
        check("t3b_s", 32'(s), 32'h0002);

        // Start while busy ignored; operand changes after the start edge ignored
        step(1);
        go(16'h1111, 16'h2222, 1'b0);
        step(1);
        a     = 16'h9999;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("t4_busy_e2", 32'(busy), 32'h1);
        a = 16'h5555;
        step(1);
        check("t4_done_e3", 32'(done), 32'h0);
        step(1);
        check("t4_done_e4", 32'(done), 32'h1);
        check("t4_s", 32'(s), 32'h3333);
        // Start accepted in the done cycle
        go(16'h5555, 16'h5555, 1'b0);
        check("t4b_busy", 32'(busy), 32'h1);
        check("t4b_s_clear", 32'(s), 32'h0);
        step(4);
        check("t4b_done", 32'(done), 32'h1);
        check("t4b_s", 32'(s), 32'h1110);
        check("t4b_cout", 32'(Cout), 32'h1);

        // Asynchronous reset mid-operation
        step(1);
        go(16'h1234, 16'h5678, 1'b0);
        check("t5_cout_hold", 32'(Cout), 32'h1);
        step(2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_s", 32'(s), 32'h0);
        check("t5_rst_cout", 32'(Cout), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_done", 32'(done), 32'h0);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("t5_no_done", 32'(done), 32'h0);
        end
        go(16'h4321, 16'h1111, 1'b0);
        step(4);
        check("t5_done", 32'(done), 32'h1);
        check("t5_s", 32'(s), 32'h5432);

`ifdef BCD_SUB_EN
        // Subtraction via nine's complement with Cin=1
        step(1);
        sub = 1'b1;
        go(16'h5000, 16'h1234, 1'b1);
        step(4);
        check("sub1_s", 32'(s), 32'h3766);
        check("sub1_cout", 32'(Cout), 32'h1);
        step(1);
        go(16'h1234, 16'h5000, 1'b1);
        step(4);
        check("sub2_s", 32'(s), 32'h6234);
        check("sub2_cout", 32'(Cout), 32'h0);
        sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Parametrised multi-digit BCD adder. Generalises the single-digit combinational BCD adder to NDIGITS packed BCD digits.
- Processes one digit per clock, from the least significant digit upward, with a digit carry register between digits.
- Uses a start/done handshake and flags non-BCD input digits.
- Used by the datapath wherever decimal operands wider than one digit are summed, for example counters and display accumulators.

Parameters:
- NDIGITS, default 4: number of BCD digits per operand. Legal range is 1..16.
- IDXW, default 4: width of the digit index counter. Must satisfy 2**IDXW >= NDIGITS.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin an addition. Sampled only when busy=0.
- a  input  4*NDIGITS  operand A, packed BCD. Digit i is a[4i+3:4i].
- b  input  4*NDIGITS  operand B, packed BCD.
- Cin  input  1  carry into digit 0.
- s  output  4*NDIGITS  BCD sum, registered.
- Cout  output  1  carry out of the top digit, registered.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when s and Cout are valid.
- err  output  1  high if any latched operand digit is greater than 9.

Behaviour:
- Reset (asynchronous, active-high) clears the following:
  - s=0, Cout=0, busy=0, done=0, err=0.
  - Internal operand registers, digit index and carry are cleared.
  - State returns to IDLE.
  - Reset asserted mid-operation aborts the addition. No done pulse is produced.
- The FSM has three states: IDLE, ADD, DONE.
- IDLE:
  - On start=1 at a rising edge (edge 0), the block latches a, b and Cin, and clears s.
  - idx is set to 0, busy is set to 1, and the state moves to ADD.
  - err is computed from the latched operands at this edge and held until the next accepted start.
- ADD, at each edge:
  - t = a_digit[idx] + b_digit[idx] + carry, computed 5 bits wide.
  - If t > 9, the result digit is (t + 6) mod 16 and the new carry is 1.
  - Otherwise the result digit is t[3:0] and the new carry is 0.
  - The result digit is written to s digit idx, and idx is incremented.
- The edge that processes idx = NDIGITS-1 (edge NDIGITS) does the following:
  - Writes the top digit and sets Cout to the final carry.
  - Sets busy=0 and done=1, and moves to DONE.
- DONE:
  - done is high for exactly one cycle, then returns to 0 at the next edge.
  - The state then behaves as IDLE, and a start in this cycle is accepted.
- Latency: done rises NDIGITS edges after the start edge. For NDIGITS=4, done is high in the cycle after edge 4.
- s and Cout hold their values after done until the next accepted start. s is cleared at that start; Cout holds until it is rewritten at edge NDIGITS.
- start while busy=1 is ignored. Operands and progress are unaffected.
- Changes on a, b or Cin after the start edge do not affect the result, because the operands are latched.
- Non-BCD digits (A–F) are not rejected. The same +6 correction is applied, so the result is deterministic but not meaningful. err=1 flags this case.
- idx never exceeds NDIGITS-1. No wrap into unused index values is allowed.

Optional Feature:
- Macro: BCD_SUB_EN.
- When defined:
  - An extra input port is added: sub, input, 1 bit, latched at start.
  - With sub=1, each b digit is replaced by its nine's complement (9 - b_digit) before the add.
  - With sub=1 and Cin=1, the block computes a - b. Cout=1 means no borrow (a >= b); Cout=0 means the result is the ten's complement of b - a.
  - The nine's complement of a digit greater than 9 still sets err.
- When not defined: the port is absent and the block performs addition only. Behaviour is identical to sub=0.

Test Plan:
- NDIGITS=4, a=0x1234, b=0x5678, Cin=0, pulse start -> done after 4 edges, s=0x6912, Cout=0, err=0. busy is high for exactly 4 cycles.
- a=0x9999, b=0x0001, Cin=0 -> s=0x0000, Cout=1. Also a=0x0000, b=0x0000, Cin=1 -> s=0x0001, Cout=0.
- a=0x12A4, b=0x0001 -> err=1 at the start edge, and done still pulses after 4 edges. Then a=0x0001, b=0x0001 -> err=0, s=0x0002.
- Start 1111+2222. Pulse start again at edge 2 with a=0x9999. Change a at edge 3 -> second start ignored, s=0x3333. A start in the done cycle is accepted immediately.
- Start an addition and assert reset asynchronously between edges 2 and 3 -> all outputs are 0 immediately and no done pulse occurs. A new start after release yields the correct sum.
- With BCD_SUB_EN defined: a=0x5000, b=0x1234, sub=1, Cin=1 -> s=0x3766, Cout=1. a=0x1234, b=0x5000 -> s=0x6234, Cout=0.
